// File: rtl/mem_preload_seq.sv
// mem_preload_seq: holds the CPU in reset while it fills the register file and data memory, then releases it.
// Define PRELOAD_CHECKSUM_EN to build the running sum of accepted memory words; otherwise checksum is tied to zero.
module mem_preload_seq #(
  parameter int          DATA_W      = 32,
  parameter int          REG_DEPTH   = 32,
  parameter int          REG_INIT_N  = 10,
  parameter int          MEM_DEPTH   = 256,
  parameter int          BYTE_MASK_W = 8,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2B3D,
  localparam int         REG_AW      = $clog2(REG_DEPTH),
  localparam int         MEM_AW      = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              dm_we,
  output logic [MEM_AW-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ready,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);
  localparam int CW = MEM_AW > REG_AW ? MEM_AW : REG_AW;
  typedef enum logic [1:0] {IDLE, REG_FILL, MEM_FILL, DONE} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [31:0]       lfsr;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] mem_data;
  logic              accept;
  logic              go;
  assign go     = (state == IDLE || state == DONE) && start;
  assign accept = state == MEM_FILL && dm_ready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      lfsr   <= LFSR_SEED;
      mode_q <= '0;
    end else
      case (state)
        IDLE, DONE:
          if (start) begin
            mode_q <= mode;
            cnt    <= '0;
            lfsr   <= LFSR_SEED;
            state  <= REG_FILL;
          end
        REG_FILL:
          if (cnt == CW'(REG_INIT_N - 1)) begin
            cnt   <= '0;
            state <= MEM_FILL;
          end else
            cnt <= cnt + 1'b1;
        MEM_FILL:
          if (dm_ready) begin
            cnt  <= cnt + 1'b1;
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
            if (cnt == CW'(MEM_DEPTH - 1)) state <= DONE;
          end
        default: state <= IDLE;
      endcase
  assign mem_data  = mode_q == 2'd0 ? DATA_W'(cnt) :
                     mode_q == 2'd1 ? DATA_W'(lfsr[BYTE_MASK_W-1:0]) : '0;
  assign reg_we    = state == REG_FILL;
  assign reg_addr  = reg_we ? cnt[REG_AW-1:0] : '0;
  assign reg_wdata = reg_we && mode_q < 2'd2 ? DATA_W'(cnt) : '0;
  assign dm_we     = state == MEM_FILL;
  assign dm_addr   = dm_we ? cnt[MEM_AW-1:0] : '0;
  assign dm_wdata  = dm_we ? mem_data : '0;
  assign cpu_hold  = state != DONE;
  assign busy      = state == REG_FILL || state == MEM_FILL;
  assign done      = state == DONE;
`ifdef PRELOAD_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) checksum <= '0;
    else if (go) checksum <= '0;
    else if (accept) checksum <= checksum + 32'(mem_data);
`else
  assign checksum = 32'h0;
`endif
endmodule

// File: tb/tb_mem_preload_seq.sv
// tb_mem_preload_seq: randomized preload runs checked against array/arithmetic reference of the expected memory image.
module tb_mem_preload_seq;
  localparam logic [31:0] SENT = 32'hFFFF_FFFF;
  logic        clk = 0, rst = 0, start = 0, dm_ready = 1;
  logic [1:0]  mode = 0;
  logic        reg_we, dm_we, cpu_hold, busy, done;
  logic [4:0]  reg_addr;
  logic [7:0]  dm_addr;
  logic [31:0] reg_wdata, dm_wdata, checksum;
  logic [31:0] reg_mem [32];
  logic [31:0] dm_mem [256];
  int tests = 0, fails = 0, n, writes;

  always #5 clk = ~clk;

  mem_preload_seq dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ready(dm_ready),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .checksum(checksum)
  );

  always @(posedge clk) begin
    if (reg_we) reg_mem[reg_addr] <= reg_wdata;
    if (dm_we && dm_ready) dm_mem[dm_addr] <= dm_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  task automatic clear_mems();
    foreach (reg_mem[i]) reg_mem[i] = SENT;
    foreach (dm_mem[i]) dm_mem[i] = SENT;
  endtask

  // kind: 0 = always ready, 1 = random stalls, 2 = five stalls at address 17
  task automatic run(input logic [1:0] m, input int kind, input bit inj);
    int cyc = 0, stalls = 0, held = 0, bad_reg = 0, bad_dm = 0;
    logic [31:0] l = 32'hACE1_2B3D, sum = 0, e;
    bit stall_here;
    clear_mems();
    @(negedge clk) mode = m; start = 1;
    @(negedge clk) start = 0; mode = 2'($urandom_range(0, 3));
    check("first_reg_we", {31'b0, reg_we}, 1);
    check("first_reg_addr", {27'b0, reg_addr}, 0);
    check("start_hold_busy", {29'b0, cpu_hold, busy, done}, 3'b110);
    while (!done && cyc < 2000) begin
      stall_here = kind == 2 && dm_we && dm_addr == 8'd17 && held < 5;
      dm_ready = kind == 1 ? ($urandom_range(0, 3) != 0) : !stall_here;
      if (stall_here) begin
        held++;
        check("stall_addr", {24'b0, dm_addr}, 17);
        check("stall_data", dm_wdata, 17);
      end
      if (dm_we && !dm_ready) stalls++;
      if (inj) start = dm_we && dm_addr == 8'd40;
      @(negedge clk) cyc++;
    end
    start = 0;
    dm_ready = 1;
    check("cycles", cyc, 266 + stalls);
    check("done_hold_busy", {29'b0, done, cpu_hold, busy}, 3'b100);
    for (int i = 0; i < 32; i++) begin
      e = i < 10 ? (m >= 2 ? 32'h0 : i) : SENT;
      if (reg_mem[i] !== e) bad_reg++;
    end
    for (int i = 0; i < 256; i++) begin
      e = m == 0 ? i : m == 1 ? {24'h0, l[7:0]} : 32'h0;
      l = lfsr_next(l);
      sum += e;
      if (dm_mem[i] !== e) bad_dm++;
    end
    check("reg_words_bad", bad_reg, 0);
    check("dm_words_bad", bad_dm, 0);
`ifdef PRELOAD_CHECKSUM_EN
    check("checksum", checksum, sum);
`else
    check("checksum", checksum, 0);
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_flags", {27'b0, reg_we, dm_we, busy, done, cpu_hold}, 5'b00001);
    check("rst_addr", {19'b0, reg_addr, dm_addr}, 0);
    check("rst_data", reg_wdata | dm_wdata, 0);
    check("rst_checksum", checksum, 0);
    rst = 1;
    @(negedge clk);
    run(2'd0, 0, 0);
`ifdef PRELOAD_CHECKSUM_EN
    check("idx_checksum", checksum, 32'h7F80);
`endif
    run(2'd1, 0, 0);
    check("lfsr_word0", dm_mem[0], 32'h3D);
    check("lfsr_word1", dm_mem[1], 32'h9D);
    run(2'd0, 2, 0);
    run(2'd0, 0, 1);
    run(2'd3, 0, 0);
    for (int k = 0; k < 4; k++) run(2'($urandom_range(0, 3)), 1, 0);
    clear_mems();
    @(negedge clk) mode = 0; start = 1;
    @(negedge clk) start = 0;
    n = 0;
    while (!(dm_we && dm_addr == 8'd100) && n < 1000) @(negedge clk) n++;
    check("reach_addr100", {24'b0, dm_addr}, 100);
    rst = 0;
    #1 check("abort_flags", {27'b0, dm_we, reg_we, cpu_hold, busy, done}, 5'b00100);
    check("partial_kept", dm_mem[99], 99);
    @(negedge clk) rst = 1;
    writes = 0;
    repeat (20) @(negedge clk) if (dm_we || reg_we) writes++;
    check("idle_writes", writes, 0);
    check("idle_hold", {31'b0, cpu_hold}, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
